// File: rtl/perf_pkg.sv
// Shared types and defaults for the retirement-side performance monitor.
// Contents: FSM state encoding and default parameter values.
// No logic; imported by pipeline_perf_monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    PM_IDLE   = 2'd0,
    PM_RUN    = 2'd1,
    PM_HALTED = 2'd2
  } pm_state_e;

  localparam int HALT_REPS_DEF = 16;
  localparam int CNT_W_DEF     = 32;
  localparam int PC_W_DEF      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible the cycle after i_en; clear has priority over i_en.
// Ports: i_clk, i_rst_n (async active-low), i_clear, i_en, o_cnt[W-1:0]; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Retirement monitor: saturating perf counters, self-loop halt detection, sticky protocol error.
// Latency: all outputs registered, one cycle after the retiring event; o_done is a 1-cycle pulse.
// Ports: i_clk/i_reset/i_clear, retirement debug inputs in; counters, halt status, error out. No backpressure.
module pipeline_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int HALT_REPS = HALT_REPS_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic [PC_W-1:0]  i_pc_debug,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_insn_cnt,
  output logic [CNT_W-1:0] o_ctrl_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt,
  output logic [PC_W-1:0]  o_halt_pc,
  output logic             o_halted,
  output logic             o_done,
  output logic             o_err
);

  localparam int REP_W = $clog2(HALT_REPS + 1);

  pm_state_e        r_state;
  pm_state_e        w_state_nxt;
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_nxt;
  logic [PC_W-1:0]  r_last_pc;
  logic [PC_W-1:0]  w_last_pc_nxt;
  logic [PC_W-1:0]  r_halt_pc;
  logic             r_done;
  logic             r_err;
  logic             w_active;
  logic             w_hit;
  logic             w_err_evt;
  logic             w_vld_x;

  // The IDLE cycle that carries the first retirement already counts as a RUN cycle.
  assign w_active = (r_state == PM_RUN) || ((r_state == PM_IDLE) && i_insn_vld);

  // Halt detector: only valid retirements move the repeat tracker; bubbles leave it alone.
  always_comb begin
    w_rep_nxt     = r_rep;
    w_last_pc_nxt = r_last_pc;
    if (w_active && i_insn_vld) begin
      if ((r_state == PM_IDLE) || (i_pc_debug != r_last_pc)) begin
        w_rep_nxt     = REP_W'(1);
        w_last_pc_nxt = i_pc_debug;
      end else begin
        w_rep_nxt = r_rep + REP_W'(1);
      end
    end
  end

  // HALT_REPS >= 2, so the IDLE retirement (rep = 1) can never hit.
  assign w_hit = (r_state == PM_RUN) && (w_rep_nxt == REP_W'(HALT_REPS));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PM_IDLE:   if (i_insn_vld) w_state_nxt = PM_RUN;
      PM_RUN:    if (w_hit)      w_state_nxt = PM_HALTED;
      PM_HALTED: w_state_nxt = PM_HALTED;
      default:   w_state_nxt = PM_IDLE;
    endcase
    if (i_clear) w_state_nxt = PM_IDLE;
  end

`ifdef SYNTHESIS
  assign w_vld_x = 1'b0;
`else
  assign w_vld_x = $isunknown(i_insn_vld);
`endif

  assign w_err_evt = (i_mispred && (!i_ctrl || !i_insn_vld))
                   || (i_ctrl && !i_insn_vld)
                   || w_vld_x;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= PM_IDLE;
      r_rep     <= '0;
      r_last_pc <= '0;
      r_halt_pc <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else if (i_clear) begin
      r_state   <= PM_IDLE;
      r_rep     <= '0;
      r_last_pc <= '0;
      r_halt_pc <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep     <= w_rep_nxt;
      r_last_pc <= w_last_pc_nxt;
      r_done    <= w_hit;
      r_err     <= r_err | w_err_evt;
      if (w_hit) r_halt_pc <= w_last_pc_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clear (i_clear),
    .i_en    (w_active),
    .o_cnt   (o_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_insn_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clear (i_clear),
    .i_en    (w_active && i_insn_vld),
    .o_cnt   (o_insn_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ctrl_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clear (i_clear),
    .i_en    (w_active && i_insn_vld && i_ctrl),
    .o_cnt   (o_ctrl_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_clear (i_clear),
    .i_en    (w_active && i_insn_vld && i_ctrl && i_mispred),
    .o_cnt   (o_mispred_cnt)
  );

  assign o_halted  = (r_state == PM_HALTED);
  assign o_done    = r_done;
  assign o_halt_pc = r_halt_pc;
  assign o_err     = r_err;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Testbench for pipeline_perf_monitor: directed steps, expected values queued and compared.
// Two instances share inputs: default widths, and CNT_W=4 for saturation.
module tb_pipeline_perf_monitor;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_insn_vld = 1'b0;
  logic        i_ctrl = 1'b0;
  logic        i_mispred = 1'b0;
  logic [31:0] i_pc_debug = '0;

  logic [31:0] o_cycle_cnt, o_insn_cnt, o_ctrl_cnt, o_mispred_cnt, o_halt_pc;
  logic        o_halted, o_done, o_err;
  logic [3:0]  s_cycle_cnt, s_insn_cnt, s_ctrl_cnt, s_mispred_cnt;
  logic [31:0] s_halt_pc;
  logic        s_halted, s_done, s_err;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  pipeline_perf_monitor #(.CNT_W(32), .PC_W(32), .HALT_REPS(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_insn_vld(i_insn_vld),
    .i_ctrl(i_ctrl), .i_mispred(i_mispred), .i_pc_debug(i_pc_debug),
    .o_cycle_cnt(o_cycle_cnt), .o_insn_cnt(o_insn_cnt), .o_ctrl_cnt(o_ctrl_cnt),
    .o_mispred_cnt(o_mispred_cnt), .o_halt_pc(o_halt_pc), .o_halted(o_halted),
    .o_done(o_done), .o_err(o_err)
  );

  pipeline_perf_monitor #(.CNT_W(4), .PC_W(32), .HALT_REPS(16)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_insn_vld(i_insn_vld),
    .i_ctrl(i_ctrl), .i_mispred(i_mispred), .i_pc_debug(i_pc_debug),
    .o_cycle_cnt(s_cycle_cnt), .o_insn_cnt(s_insn_cnt), .o_ctrl_cnt(s_ctrl_cnt),
    .o_mispred_cnt(s_mispred_cnt), .o_halt_pc(s_halt_pc), .o_halted(s_halted),
    .o_done(s_done), .o_err(s_err)
  );

  typedef struct {
    string       tag;
    int          which;  // 0 = main instance, 1 = 4-bit instance
    logic [31:0] cyc, insn, ctrl, mis, hpc;
    logic        halted, done, err;
  } exp_t;

  exp_t sb[$];

  task automatic expect_state(input string tag, input int which,
                              input logic [31:0] cyc, insn, ctrl, mis, hpc,
                              input logic halted, done, err);
    exp_t e;
    e.tag = tag; e.which = which;
    e.cyc = cyc; e.insn = insn; e.ctrl = ctrl; e.mis = mis; e.hpc = hpc;
    e.halted = halted; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    if (e.which == 0) begin
      chk({e.tag, ".cycle"},   o_cycle_cnt,   e.cyc);
      chk({e.tag, ".insn"},    o_insn_cnt,    e.insn);
      chk({e.tag, ".ctrl"},    o_ctrl_cnt,    e.ctrl);
      chk({e.tag, ".mispred"}, o_mispred_cnt, e.mis);
      chk({e.tag, ".halt_pc"}, o_halt_pc,     e.hpc);
      chk({e.tag, ".halted"},  {31'd0, o_halted}, {31'd0, e.halted});
      chk({e.tag, ".done"},    {31'd0, o_done},   {31'd0, e.done});
      chk({e.tag, ".err"},     {31'd0, o_err},    {31'd0, e.err});
    end else begin
      chk({e.tag, ".sat_cycle"},   {28'd0, s_cycle_cnt},   e.cyc);
      chk({e.tag, ".sat_insn"},    {28'd0, s_insn_cnt},    e.insn);
      chk({e.tag, ".sat_ctrl"},    {28'd0, s_ctrl_cnt},    e.ctrl);
      chk({e.tag, ".sat_mispred"}, {28'd0, s_mispred_cnt}, e.mis);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic step(input logic v, input logic c, input logic m,
                      input logic [31:0] pc, input logic clr = 1'b0);
    i_insn_vld = v; i_ctrl = c; i_mispred = m; i_pc_debug = pc; i_clear = clr;
    @(posedge i_clk);
    #1;
    i_insn_vld = 1'b0; i_ctrl = 1'b0; i_mispred = 1'b0; i_clear = 1'b0;
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    // ---- reset state
    #12;
    expect_state("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    #2 i_reset = 1'b1;
    @(posedge i_clk); #1;

    // ---- 1: ten plain retirements
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 32'(4 * k));
    expect_state("t1_plain", 0, 10, 10, 0, 0, 0, 0, 0, 0);
    compare_front();
    do_clear();
    expect_state("t1_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();

    // ---- 2: mixed retirements with bubbles: 8 retirements, 4 bubbles
    step(1'b1, 1'b0, 1'b0, 32'h100);
    bubble();
    step(1'b1, 1'b1, 1'b0, 32'h104);
    step(1'b1, 1'b1, 1'b1, 32'h108);
    bubble();
    bubble();
    step(1'b1, 1'b0, 1'b0, 32'h10c);
    step(1'b1, 1'b1, 1'b0, 32'h110);
    bubble();
    step(1'b1, 1'b0, 1'b0, 32'h114);
    step(1'b1, 1'b0, 1'b0, 32'h118);
    step(1'b1, 1'b0, 1'b0, 32'h11c);
    expect_state("t2_mixed", 0, 12, 8, 3, 1, 0, 0, 0, 0);
    compare_front();
    bubble();
    expect_state("t2_bubble_counts", 0, 13, 8, 3, 1, 0, 0, 0, 0);
    compare_front();
    do_clear();

    // ---- 3: self-loop halt at 0x8
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h4);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 32'h8);
    bubble();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 1'b0, 32'h8);
    expect_state("t3_rep15", 0, 18, 17, 0, 0, 0, 0, 0, 0);
    compare_front();
    step(1'b1, 1'b0, 1'b0, 32'h8);
    expect_state("t3_halt", 0, 19, 18, 0, 0, 32'h8, 1, 1, 0);
    compare_front();
    step(1'b1, 1'b1, 1'b0, 32'h200);
    expect_state("t3_frozen", 0, 19, 18, 0, 0, 32'h8, 1, 0, 0);
    compare_front();
    bubble();
    expect_state("t3_frozen2", 0, 19, 18, 0, 0, 32'h8, 1, 0, 0);
    compare_front();

    // ---- 4: protocol errors and clear
    do_clear();
    expect_state("t4_cleared_halt", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    step(1'b1, 1'b0, 1'b1, 32'h40);
    expect_state("t4_err_set", 0, 1, 1, 0, 0, 0, 0, 0, 1);
    compare_front();
    bubble();
    expect_state("t4_err_sticky", 0, 2, 1, 0, 0, 0, 0, 0, 1);
    compare_front();
    do_clear();
    bubble();
    expect_state("t4_idle_after_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    expect_state("t4_ctrl_no_vld", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    compare_front();
    do_clear();

    // ---- 5: clear coincides with the 16th repeat
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0, 32'h8);
    expect_state("t5_rep15", 0, 15, 15, 0, 0, 0, 0, 0, 0);
    compare_front();
    step(1'b1, 1'b0, 1'b0, 32'h8, 1'b1);
    expect_state("t5_clear_wins", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    bubble();
    expect_state("t5_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();

    // ---- 6: saturation at CNT_W=4, then async reset off the edge
    do_clear();
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(4 * k));
    expect_state("t6_wide", 0, 20, 20, 20, 0, 0, 0, 0, 0);
    compare_front();
    expect_state("t6_sat", 1, 15, 15, 15, 0, 0, 0, 0, 0);
    compare_front();
    #2 i_reset = 1'b0;
    #1;
    expect_state("t6_async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    expect_state("t6_async_rst_sat", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    compare_front();
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    step(1'b1, 1'b0, 1'b0, 32'h300);
    expect_state("t6_after_rst", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    compare_front();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
